// File: rtl/roi_bbox_detect_pkg.sv
//------------------------------------------------------------------------------
// Module  : bbox_pkg
// Brief   : Shared types and default constants for the ROI bounding-box block.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package bbox_pkg;

  localparam int C_DATA_W   = 10;
  localparam int C_H_ACTIVE = 640;
  localparam int C_V_ACTIVE = 480;
  localparam int C_CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/roi_bbox_detect_if.sv
//------------------------------------------------------------------------------
// Module  : bbox_pix_if
// Brief   : Pixel stream qualifiers (valid + start-of-frame) shared between the
//           stream source and the raster position counter.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bbox_pix_if;

  logic dval;
  logic sof;

  modport master (output dval, output sof);
  modport slave  (input  dval, input  sof);

endinterface

`default_nettype wire

// File: rtl/roi_bbox_detect_pix_pos_counter.sv
//------------------------------------------------------------------------------
// Module  : pix_pos_counter
// Brief   : Raster X/Y counter for accepted pixels. iSOF forces the current
//           pixel to (0,0); flags the first and the frame-end pixel.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pix_pos_counter
  import bbox_pkg::*;
#(
  parameter int H_ACTIVE = C_H_ACTIVE,
  parameter int V_ACTIVE = C_V_ACTIVE,
  parameter int CNT_W    = C_CNT_W
) (
  input  wire logic             iCLK,
  input  wire logic             iRST,
  bbox_pix_if.slave             pix,
  output logic [CNT_W-1:0]      o_x,
  output logic [CNT_W-1:0]      o_y,
  output logic                  o_first,
  output logic                  o_last
);

  localparam logic [CNT_W-1:0] C_X_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] C_Y_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic [CNT_W-1:0] w_x;
  logic [CNT_W-1:0] w_y;

  // Effective position of the pixel on the bus: an accepted SOF realigns to (0,0).
  always_comb begin
    w_x     = (pix.dval && pix.sof) ? '0 : r_x;
    w_y     = (pix.dval && pix.sof) ? '0 : r_y;
    o_x     = w_x;
    o_y     = w_y;
    o_first = pix.dval && (w_x == '0) && (w_y == '0);
    o_last  = pix.dval && (w_x == C_X_LAST) && (w_y == C_Y_LAST);
  end

  // Advance the raster position on every accepted pixel.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_x <= '0;
      r_y <= '0;
    end else if (pix.dval) begin
      if (o_last) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_x == C_X_LAST) begin
        r_x <= '0;
        r_y <= w_y + C_ONE;
      end else begin
        r_x <= w_x + C_ONE;
        r_y <= w_y;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/roi_bbox_detect.sv
//------------------------------------------------------------------------------
// Module  : roi_bbox_detect
// Brief   : Per-frame bounding box of pixels inside a region of interest whose
//           value is at or below a threshold. Optional matching-pixel count
//           output oCOUNT when BBOX_PIXCOUNT_EN is defined.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module roi_bbox_detect
  import bbox_pkg::*;
#(
  parameter int DATA_W   = C_DATA_W,
  parameter int H_ACTIVE = C_H_ACTIVE,
  parameter int V_ACTIVE = C_V_ACTIVE,
  parameter int CNT_W    = C_CNT_W
) (
  input  wire logic               iCLK,
  input  wire logic               iRST,
  input  wire logic               iDVAL,
  input  wire logic               iSOF,
  input  wire logic [DATA_W-1:0]  iDATA,
  input  wire logic [DATA_W-1:0]  iTHRESH,
  input  wire logic [CNT_W-1:0]   iX_LO,
  input  wire logic [CNT_W-1:0]   iX_HI,
  input  wire logic [CNT_W-1:0]   iY_LO,
  input  wire logic [CNT_W-1:0]   iY_HI,
  output logic                    oDVAL,
  output logic                    oFRAME_DONE,
  output logic                    oFOUND,
`ifdef BBOX_PIXCOUNT_EN
  output logic [CNT_W+CNT_W-1:0]  oCOUNT,
`endif
  output logic [CNT_W-1:0]        oXSTART,
  output logic [CNT_W-1:0]        oXEND,
  output logic [CNT_W-1:0]        oYSTART,
  output logic [CNT_W-1:0]        oYEND
);

  bbox_pix_if u_pix ();

  assign u_pix.dval = iDVAL;
  assign u_pix.sof  = iSOF;

  logic [CNT_W-1:0] w_x;
  logic [CNT_W-1:0] w_y;
  logic             w_first;
  logic             w_last;

  pix_pos_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .CNT_W    (CNT_W)
  ) u_pos (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .pix     (u_pix),
    .o_x     (w_x),
    .o_y     (w_y),
    .o_first (w_first),
    .o_last  (w_last)
  );

  state_t            r_state;

  // Shadow copies of the frame configuration, captured at pixel (0,0).
  logic [CNT_W-1:0]  r_x_lo, r_x_hi, r_y_lo, r_y_hi;
  logic [DATA_W-1:0] r_thresh;

  // Running accumulators for the frame in progress.
  logic              r_hit;
  logic [CNT_W-1:0]  r_xmin, r_xmax, r_ymin, r_ymax;

  // Registered results.
  logic              r_dval_q;
  logic              r_done;
  logic              r_found;
  logic [CNT_W-1:0]  r_xs, r_xe, r_ys, r_ye;

  logic [CNT_W-1:0]  w_x_lo, w_x_hi, w_y_lo, w_y_hi;
  logic [DATA_W-1:0] w_thresh;
  logic              w_live;
  logic              w_match;
  logic              w_hit_n;
  logic [CNT_W-1:0]  w_xmin_n, w_xmax_n, w_ymin_n, w_ymax_n;

  // Pixel (0,0) is judged against the live inputs it is about to latch.
  always_comb begin
    w_x_lo   = w_first ? iX_LO   : r_x_lo;
    w_x_hi   = w_first ? iX_HI   : r_x_hi;
    w_y_lo   = w_first ? iY_LO   : r_y_lo;
    w_y_hi   = w_first ? iY_HI   : r_y_hi;
    w_thresh = w_first ? iTHRESH : r_thresh;
    w_live   = iDVAL && (w_first || (r_state == SCAN));
    w_match  = w_live &&
               (w_x >= w_x_lo) && (w_x <= w_x_hi) &&
               (w_y >= w_y_lo) && (w_y <= w_y_hi) &&
               (iDATA <= w_thresh);
  end

  // Next accumulator values; a new frame starts from a cleared box.
  always_comb begin
    w_hit_n  = w_first ? 1'b0 : r_hit;
    w_xmin_n = w_first ? '0   : r_xmin;
    w_xmax_n = w_first ? '0   : r_xmax;
    w_ymin_n = w_first ? '0   : r_ymin;
    w_ymax_n = w_first ? '0   : r_ymax;
    if (w_match) begin
      if (!w_hit_n) begin
        w_xmin_n = w_x;
        w_xmax_n = w_x;
        w_ymin_n = w_y;
        w_ymax_n = w_y;
      end else begin
        if (w_x < w_xmin_n) w_xmin_n = w_x;
        if (w_x > w_xmax_n) w_xmax_n = w_x;
        if (w_y < w_ymin_n) w_ymin_n = w_y;
        if (w_y > w_ymax_n) w_ymax_n = w_y;
      end
      w_hit_n = 1'b1;
    end
  end

`ifdef BBOX_PIXCOUNT_EN
  logic [CNT_W+CNT_W-1:0] r_cnt;
  logic [CNT_W+CNT_W-1:0] r_count;
  logic [CNT_W+CNT_W-1:0] w_cnt_n;

  // Matching-pixel count, saturating at all-ones.
  always_comb begin
    w_cnt_n = w_first ? '0 : r_cnt;
    if (w_match && (w_cnt_n != '1)) w_cnt_n = w_cnt_n + (CNT_W+CNT_W)'(1);
  end

  // Count accumulator and its reported copy.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_cnt   <= '0;
      r_count <= '0;
    end else begin
      if (w_live) r_cnt <= w_cnt_n;
      if ((r_state == SCAN) && w_last) r_count <= w_cnt_n;
    end
  end

  assign oCOUNT = r_count;
`endif

  // Frame state machine with shadow capture, accumulation and result registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state  <= IDLE;
      r_x_lo   <= '0;
      r_x_hi   <= '0;
      r_y_lo   <= '0;
      r_y_hi   <= '0;
      r_thresh <= '0;
      r_hit    <= 1'b0;
      r_xmin   <= '0;
      r_xmax   <= '0;
      r_ymin   <= '0;
      r_ymax   <= '0;
      r_dval_q <= 1'b0;
      r_done   <= 1'b0;
      r_found  <= 1'b0;
      r_xs     <= '0;
      r_xe     <= '0;
      r_ys     <= '0;
      r_ye     <= '0;
    end else begin
      r_dval_q <= iDVAL;
      r_done   <= 1'b0;
      if (w_first) begin
        r_x_lo   <= iX_LO;
        r_x_hi   <= iX_HI;
        r_y_lo   <= iY_LO;
        r_y_hi   <= iY_HI;
        r_thresh <= iTHRESH;
      end
      if (w_live) begin
        r_hit  <= w_hit_n;
        r_xmin <= w_xmin_n;
        r_xmax <= w_xmax_n;
        r_ymin <= w_ymin_n;
        r_ymax <= w_ymax_n;
      end
      case (r_state)
        IDLE: begin
          if (w_first) r_state <= SCAN;
        end
        SCAN: begin
          if (w_last) begin
            r_state <= REPORT;
            r_done  <= 1'b1;
            r_found <= w_hit_n;
            r_xs    <= w_xmin_n;
            r_xe    <= w_xmax_n;
            r_ys    <= w_ymin_n;
            r_ye    <= w_ymax_n;
          end
        end
        REPORT: begin
          r_state <= iDVAL ? SCAN : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign oDVAL       = r_dval_q;
  assign oFRAME_DONE = r_done;
  assign oFOUND      = r_found;
  assign oXSTART     = r_xs;
  assign oXEND       = r_xe;
  assign oYSTART     = r_ys;
  assign oYEND       = r_ye;

endmodule

`default_nettype wire

// File: doc/roi_bbox_detect.md
ROI_BBOX_DETECT -- requirements
Module: roi_bbox_detect

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_W, 10, pixel data width
  H_ACTIVE, 640, active pixels per line
  V_ACTIVE, 480, active lines per frame
  CNT_W, 16, width of all coordinate counters and coordinate ports
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  iCLK  in  1  sole clock; all logic on rising edge
  iRST  in  1  reset, synchronous, active-high
  iDVAL  in  1  pixel valid
  iSOF  in  1  start of frame; qualified by iDVAL
  iDATA  in  DATA_W  pixel value
  iTHRESH  in  DATA_W  match threshold
  iX_LO, iX_HI  in  CNT_W  ROI column bounds, inclusive
  iY_LO, iY_HI  in  CNT_W  ROI row bounds, inclusive
  oDVAL  out  1  iDVAL delayed one cycle
  oFRAME_DONE  out  1  one-cycle pulse; a new result is valid
  oFOUND  out  1  at least one match in last completed frame
  oXSTART, oXEND, oYSTART, oYEND  out  CNT_W  bounding box of matches
REQ-003 The block SHALL use one clock, iCLK; reset iRST SHALL be synchronous and active-high.

Function
REQ-004 A pixel SHALL be accepted only on a cycle with iDVAL=1; the position counters (X, Y) SHALL advance only on accepted pixels.
REQ-005 X SHALL wrap from H_ACTIVE-1 to 0 and increment Y; the accepted pixel at (H_ACTIVE-1, V_ACTIVE-1) SHALL be the frame-end pixel, after which X=Y=0.
REQ-006 An accepted pixel with iSOF=1 SHALL be taken as (0,0) regardless of the counters; if the counters were not at (0,0), the partial frame SHALL be discarded with no oFRAME_DONE.
REQ-007 ROI bounds and iTHRESH SHALL be sampled into shadow registers on acceptance of pixel (0,0) and SHALL be held constant for the rest of the frame; pixel (0,0) itself SHALL be evaluated against the newly sampled values.
REQ-008 A pixel SHALL match when it is accepted, iY_LO<=Y<=iY_HI, iX_LO<=X<=iX_HI, and iDATA<=iTHRESH (unsigned).
REQ-009 Per frame, the accumulators SHALL track the minimum and maximum X and Y over all matching pixels, plus a hit flag.
REQ-010 The state machine SHALL have states IDLE (after reset, waiting for pixel (0,0)), SCAN (accumulating) and REPORT (one cycle); IDLE->SCAN on accepting (0,0); SCAN->REPORT on accepting the frame-end pixel; REPORT->SCAN if a pixel is accepted in that cycle, else REPORT->IDLE.
REQ-011 In REPORT, oFRAME_DONE SHALL be 1 for exactly one cycle, which SHALL be the cycle after the frame-end pixel is accepted; the result outputs SHALL update on the same edge that asserts oFRAME_DONE.
REQ-012 A pixel accepted during REPORT SHALL be processed as pixel (0,0) of the next frame with freshly cleared accumulators; no pixel SHALL be lost when iDVAL is held high back-to-back.
REQ-013 Frames with no match SHALL report oFOUND=0 with all four coordinates 0; an empty ROI (LO>HI on either axis) SHALL produce no matches.
REQ-014 Result outputs SHALL hold their values between oFRAME_DONE pulses.
REQ-015 oDVAL SHALL equal iDVAL delayed by one cycle.

Reset
REQ-016 While iRST=1, the block SHALL clear counters, accumulators and shadow registers, enter IDLE, and drive every output to 0; an in-progress frame SHALL be abandoned without a report.

Configuration
REQ-017 With macro BBOX_PIXCOUNT_EN defined, the block SHALL add output oCOUNT (out, CNT_W+CNT_W bits) giving the number of matching pixels in the last completed frame; it SHALL update with the other results and saturate at its all-ones value. Without the macro, neither the port nor its counter SHALL exist.

Structure
REQ-018 Package bbox_pkg SHALL hold the state enum (IDLE/SCAN/REPORT) and the default constants for H_ACTIVE, V_ACTIVE and CNT_W.
REQ-019 The X/Y raster counting with iSOF realignment and frame-end detection SHALL be in sub-module pix_pos_counter.

Verification
REQ-020 Use H_ACTIVE=8, V_ACTIVE=6, ROI x 1..6, y 1..4, iTHRESH=0, and zero pixels at (2,1) and (5,3) -> one oFRAME_DONE; oFOUND=1; XSTART=2, XEND=5, YSTART=1, YEND=3.
REQ-021 All pixels 0, except those in the ROI, which are set to max -> oFOUND=0 and all coordinates 0.
REQ-022 Two back-to-back frames with iDVAL held high, second frame match at (6,4) only -> the second report shows 6,6,4,4, with no pixel lost.
REQ-023 iSOF asserted at mid-frame (3,2) -> no oFRAME_DONE for the aborted frame; the next report covers only pixels from the iSOF frame onward.
REQ-024 iRST asserted mid-frame with a pending match -> all outputs become 0 and no pulse occurs until a complete new frame is seen.
